// File: rtl/piso.sv
// Parallel-in, serial-out shift register with side-band valid.
// Load wins over shift; zeros fill in behind the word.
module piso #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             load,
  output logic             q,
  output logic             valid
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_nx;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nx;

  always_comb begin
    sreg_nx = sreg;
    cnt_nx  = cnt;
    if (load) begin
      sreg_nx = d;
      cnt_nx  = CW'(WIDTH);
    end else begin
      if (MSB_FIRST) begin
        sreg_nx = {sreg[WIDTH-2:0], 1'b0};
      end else begin
        sreg_nx = {1'b0, sreg[WIDTH-1:1]};
      end
      if (cnt != '0) begin
        cnt_nx = cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg <= '0;
      cnt  <= '0;
    end else begin
      sreg <= sreg_nx;
      cnt  <= cnt_nx;
    end
  end

  // first bit is visible straight after the loading edge
  assign q     = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
  assign valid = (cnt != '0);

endmodule

// File: tb/tb_piso.sv
// Directed bench for piso: one MSB-first and one LSB-first instance.
// Outputs are checked 1 time unit after each rising edge.
module tb_piso;

  logic       clk;
  logic       rst;
  logic [3:0] m_d;
  logic       m_load;
  logic       m_q;
  logic       m_valid;
  logic [3:0] l_d;
  logic       l_load;
  logic       l_q;
  logic       l_valid;

  int total;
  int bad;

  piso #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk   (clk),
    .rst   (rst),
    .d     (m_d),
    .load  (m_load),
    .q     (m_q),
    .valid (m_valid)
  );

  piso #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk   (clk),
    .rst   (rst),
    .d     (l_d),
    .load  (l_load),
    .q     (l_q),
    .valid (l_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input bit lsb,
                     input logic eq, input logic ev);
    logic oq;
    logic ov;
    oq = lsb ? l_q : m_q;
    ov = lsb ? l_valid : m_valid;
    total++;
    assert (oq === eq) else begin
      bad++;
      $error("FAIL %s q observed=%b expected=%b", tag, oq, eq);
    end
    total++;
    assert (ov === ev) else begin
      bad++;
      $error("FAIL %s valid observed=%b expected=%b", tag, ov, ev);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nxt(input string tag, input bit lsb,
                     input logic eq, input logic ev);
    tick();
    chk(tag, lsb, eq, ev);
  endtask

  task automatic ld(input bit lsb, input logic [3:0] w);
    if (lsb) begin
      l_d    = w;
      l_load = 1'b1;
    end else begin
      m_d    = w;
      m_load = 1'b1;
    end
    tick();
    m_load = 1'b0;
    l_load = 1'b0;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst    = 1'b0;
    m_d    = 4'b1111;
    m_load = 1'b1;
    l_d    = 4'b1111;
    l_load = 1'b1;

    // reset held with load active
    nxt("rst0", 1'b0, 1'b0, 1'b0);
    chk("rst0l", 1'b1, 1'b0, 1'b0);
    nxt("rst1", 1'b0, 1'b0, 1'b0);
    nxt("rst2", 1'b0, 1'b0, 1'b0);
    chk("rst2l", 1'b1, 1'b0, 1'b0);
    m_load = 1'b0;
    l_load = 1'b0;
    rst    = 1'b1;
    nxt("rel0", 1'b0, 1'b0, 1'b0);
    nxt("rel1", 1'b0, 1'b0, 1'b0);
    chk("rel1l", 1'b1, 1'b0, 1'b0);

    // single word 1001 MSB first
    ld(1'b0, 4'b1001);
    chk("one_b0", 1'b0, 1'b1, 1'b1);
    nxt("one_b1", 1'b0, 1'b0, 1'b1);
    nxt("one_b2", 1'b0, 1'b0, 1'b1);
    nxt("one_b3", 1'b0, 1'b1, 1'b1);
    nxt("one_e0", 1'b0, 1'b0, 1'b0);
    nxt("one_e1", 1'b0, 1'b0, 1'b0);
    nxt("one_e2", 1'b0, 1'b0, 1'b0);

    // back-to-back 1010 then 0111
    ld(1'b0, 4'b1010);
    chk("b2b_0", 1'b0, 1'b1, 1'b1);
    nxt("b2b_1", 1'b0, 1'b0, 1'b1);
    nxt("b2b_2", 1'b0, 1'b1, 1'b1);
    nxt("b2b_3", 1'b0, 1'b0, 1'b1);
    ld(1'b0, 4'b0111);
    chk("b2b_4", 1'b0, 1'b0, 1'b1);
    nxt("b2b_5", 1'b0, 1'b1, 1'b1);
    nxt("b2b_6", 1'b0, 1'b1, 1'b1);
    nxt("b2b_7", 1'b0, 1'b1, 1'b1);
    nxt("b2b_e", 1'b0, 1'b0, 1'b0);

    // reload after two bits
    ld(1'b0, 4'b1100);
    chk("rld_0", 1'b0, 1'b1, 1'b1);
    nxt("rld_1", 1'b0, 1'b1, 1'b1);
    ld(1'b0, 4'b0011);
    chk("rld_2", 1'b0, 1'b0, 1'b1);
    nxt("rld_3", 1'b0, 1'b0, 1'b1);
    nxt("rld_4", 1'b0, 1'b1, 1'b1);
    nxt("rld_5", 1'b0, 1'b1, 1'b1);
    nxt("rld_e", 1'b0, 1'b0, 1'b0);

    // load held for two edges: q shows first bit of latest d
    m_d    = 4'b0110;
    m_load = 1'b1;
    tick();
    chk("hold_0", 1'b0, 1'b0, 1'b1);
    m_d = 4'b1000;
    tick();
    m_load = 1'b0;
    chk("hold_1", 1'b0, 1'b1, 1'b1);
    nxt("hold_2", 1'b0, 1'b0, 1'b1);
    nxt("hold_3", 1'b0, 1'b0, 1'b1);
    nxt("hold_4", 1'b0, 1'b0, 1'b1);
    nxt("hold_e", 1'b0, 1'b0, 1'b0);

    // async reset between edges
    ld(1'b0, 4'b1111);
    chk("ar_0", 1'b0, 1'b1, 1'b1);
    nxt("ar_1", 1'b0, 1'b1, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_drop", 1'b0, 1'b0, 1'b0);
    nxt("ar_held", 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    nxt("ar_rel0", 1'b0, 1'b0, 1'b0);
    nxt("ar_rel1", 1'b0, 1'b0, 1'b0);

    // LSB first
    ld(1'b1, 4'b1001);
    chk("lsb9_0", 1'b1, 1'b1, 1'b1);
    nxt("lsb9_1", 1'b1, 1'b0, 1'b1);
    nxt("lsb9_2", 1'b1, 1'b0, 1'b1);
    nxt("lsb9_3", 1'b1, 1'b1, 1'b1);
    nxt("lsb9_e", 1'b1, 1'b0, 1'b0);
    ld(1'b1, 4'b0001);
    chk("lsb1_0", 1'b1, 1'b1, 1'b1);
    nxt("lsb1_1", 1'b1, 1'b0, 1'b1);
    nxt("lsb1_2", 1'b1, 1'b0, 1'b1);
    nxt("lsb1_3", 1'b1, 1'b0, 1'b1);
    nxt("lsb1_e", 1'b1, 1'b0, 1'b0);
    chk("lsb_msb_idle", 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
